// File: rtl/cr16_ctrl_pkg.sv
// Shared encodings for the CR16 multi-cycle control unit: FSM states,
// opcode/ext fields, condition codes, PSR bit positions and write-back selects.
package cr16_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_MEM    = 2'd3
    } state_t;

    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_MEMJ   = 4'h4;
    localparam logic [3:0] OP_BCOND  = 4'hC;

    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;
    localparam logic [3:0] EXT_SCOND = 4'hD;

    localparam logic [3:0] ALU_CMP   = 4'hB;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;

    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    localparam logic [1:0] WB_PC_RA = 2'd0;
    localparam logic [1:0] WB_COND  = 2'd1;
    localparam logic [1:0] WB_ALU   = 2'd2;
    localparam logic [1:0] WB_MEM   = 2'd3;

    // Opcodes (or R-type ext values) that the reg_alu datapath executes.
    function automatic logic is_alu_code(input logic [3:0] code);
        return (code == 4'h1) || (code == 4'h2) || (code == 4'h3) ||
               (code == 4'h5) || (code == 4'h9) || (code == 4'hB) ||
               (code == 4'hD);
    endfunction

endpackage

// File: rtl/cr16_ctrl_cond_eval.sv
// Condition-code evaluator shared by Bcond, Jcond and Scond; evaluates a
// 4-bit condition against the latched {N,Z,F,L,C} flags.
module cond_eval
    import cr16_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_psr,
    output logic       o_taken
);

    logic w_n, w_z, w_f, w_l, w_c;

    assign w_n = i_psr[PSR_N];
    assign w_z = i_psr[PSR_Z];
    assign w_f = i_psr[PSR_F];
    assign w_l = i_psr[PSR_L];
    assign w_c = i_psr[PSR_C];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            CC_EQ:   o_taken = w_z;
            CC_NE:   o_taken = !w_z;
            CC_CS:   o_taken = w_c;
            CC_CC:   o_taken = !w_c;
            CC_HI:   o_taken = w_l;
            CC_LS:   o_taken = !w_l;
            CC_GT:   o_taken = w_n;
            CC_LE:   o_taken = !w_n;
            CC_FS:   o_taken = w_f;
            CC_FC:   o_taken = !w_f;
            CC_LO:   o_taken = !w_l && !w_z;
            CC_HS:   o_taken = w_l || w_z;
            CC_LT:   o_taken = !w_n && !w_z;
            CC_GE:   o_taken = w_n || w_z;
            CC_UC:   o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_ctrl.sv
// CR16 multi-cycle control unit: fetch/decode/exec/mem sequencing, PC, IR and PSR.
// Optional jumps (Bcond, Jcond, JAL) are enabled by defining CTRL_JUMP_EN.
//
// state  | meaning
// FETCH  | present pc on mem_addr
// DECODE | capture instruction word into IR
// EXEC   | drive decoded controls; update pc/psr (LOAD issues its address)
// MEM    | LOAD write-back of memory data, then pc+1
module cr16_ctrl
    import cr16_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_dSrc,
    input  logic [4:0]  i_psrIn,
    output logic        o_write,
    output logic        o_IMM_MUX,
    output logic        o_COND_RSLT,
    output logic [1:0]  o_WB_MUX,
    output logic [3:0]  o_rSrc,
    output logic [3:0]  o_rDst,
    output logic [3:0]  o_aluOp,
    output logic [7:0]  o_imm,
    output logic [15:0] o_pc_ra,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [4:0]  o_psr
);

`ifdef CTRL_JUMP_EN
    localparam logic JUMP_EN = 1'b1;
`else
    localparam logic JUMP_EN = 1'b0;
`endif

    state_t      r_state, w_state_next;
    logic [15:0] r_pc, w_pc_next;
    logic [15:0] r_ir;
    logic [4:0]  r_psr;

    logic [3:0]  w_op, w_rd, w_ext, w_rs;
    logic        w_is_rtype, w_is_itype, w_is_alu, w_is_memj;
    logic        w_is_load, w_is_stor, w_is_jal, w_is_jcond, w_is_scond, w_is_bcond;
    logic [3:0]  w_cond_sel;
    logic        w_taken;
    logic [15:0] w_pc_inc, w_br_off;
    logic        w_ir_load, w_psr_upd;
    logic        w_write, w_mem_we, w_cond_rslt;
    logic [1:0]  w_wb;
    logic [15:0] w_addr;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:8];
    assign w_ext = r_ir[7:4];
    assign w_rs  = r_ir[3:0];

    assign w_is_rtype = (w_op == OP_RTYPE) && is_alu_code(w_ext);
    assign w_is_itype = is_alu_code(w_op);
    assign w_is_alu   = w_is_rtype || w_is_itype;
    assign w_is_memj  = (w_op == OP_MEMJ);
    assign w_is_load  = w_is_memj && (w_ext == EXT_LOAD);
    assign w_is_stor  = w_is_memj && (w_ext == EXT_STOR);
    assign w_is_scond = w_is_memj && (w_ext == EXT_SCOND);
    // With jumps disabled these collapse to NOP encodings.
    assign w_is_jal   = JUMP_EN && w_is_memj && (w_ext == EXT_JAL);
    assign w_is_jcond = JUMP_EN && w_is_memj && (w_ext == EXT_JCOND);
    assign w_is_bcond = JUMP_EN && (w_op == OP_BCOND);

    // Scond tests the condition in rs; Bcond/Jcond carry it in the rd field.
    assign w_cond_sel = w_is_scond ? w_rs : w_rd;

    cond_eval u_cond_eval (
        .i_cond  (w_cond_sel),
        .i_psr   (r_psr),
        .o_taken (w_taken)
    );

    assign w_pc_inc = r_pc + 16'd1;
    assign w_br_off = {{8{r_ir[7]}}, r_ir[7:0]};

    assign o_rSrc    = w_rs;
    assign o_rDst    = w_rd;
    assign o_imm     = r_ir[7:0];
    assign o_aluOp   = w_is_rtype ? w_ext : w_op;
    assign o_IMM_MUX = w_is_itype;
    assign o_pc_ra   = w_pc_inc;
    assign o_psr     = r_psr;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_load    = 1'b0;
        w_psr_upd    = 1'b0;
        w_write      = 1'b0;
        w_mem_we     = 1'b0;
        w_cond_rslt  = 1'b0;
        w_addr       = r_pc;

        if (w_is_jal) begin
            w_wb = WB_PC_RA;
        end else if (w_is_scond) begin
            w_wb = WB_COND;
        end else if (w_is_load) begin
            w_wb = WB_MEM;
        end else begin
            w_wb = WB_ALU;
        end

        case (r_state)
            ST_FETCH: begin
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_ir_load    = 1'b1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_next = ST_FETCH;
                w_pc_next    = w_pc_inc;
                if (w_is_alu) begin
                    w_write   = (o_aluOp != ALU_CMP);
                    w_psr_upd = 1'b1;
                end
                if (w_is_load) begin
                    w_state_next = ST_MEM;
                    w_pc_next    = r_pc;
                    w_addr       = i_dSrc;
                end
                if (w_is_stor) begin
                    w_addr   = i_dSrc;
                    w_mem_we = 1'b1;
                end
                if (w_is_jal) begin
                    w_write   = 1'b1;
                    w_pc_next = i_dSrc;
                end
                if (w_is_jcond && w_taken) begin
                    w_pc_next = i_dSrc;
                end
                if (w_is_bcond && w_taken) begin
                    w_pc_next = r_pc + w_br_off;
                end
                if (w_is_scond) begin
                    w_write     = 1'b1;
                    w_cond_rslt = w_taken;
                end
            end
            ST_MEM: begin
                w_state_next = ST_FETCH;
                w_pc_next    = w_pc_inc;
                w_write      = w_is_load;
                w_addr       = i_dSrc;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase

        // Reset kills the in-flight instruction on this very edge.
        if (!i_rst_n) begin
            w_write     = 1'b0;
            w_mem_we    = 1'b0;
            w_cond_rslt = 1'b0;
            w_addr      = RESET_PC;
        end
    end

    assign o_write     = w_write;
    assign o_mem_we    = w_mem_we;
    assign o_COND_RSLT = w_cond_rslt;
    assign o_WB_MUX    = w_wb;
    assign o_mem_addr  = w_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
            r_psr   <= 5'b00000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_ir_load) begin
                r_ir <= i_instr;
            end
            if (w_psr_upd) begin
                r_psr <= i_psrIn;
            end
        end
    end

endmodule
